// File: rtl/req_encoder_4to2.sv
// ============================================================================
// Module   : req_encoder_4to2
// Captures four request lines into a pending register and offers the selected
// index as a 2-bit code on a valid/ready handshake. Optional macro:
// ROUND_ROBIN_EN (rotating priority after each accepted grant).
// Revision : 1.0
// ============================================================================
`default_nettype none

module req_encoder_4to2 #(
    parameter int EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_req,
    input  logic       i_clr,
    input  logic       i_ready,
    output logic [1:0] o_code,
    output logic       o_valid,
    output logic [3:0] o_pending,
    output logic       o_overflow
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_req_d;
    logic [3:0] r_pending;
    logic [1:0] r_code;
    logic       r_valid;
    logic       r_overflow;
    logic [1:0] w_code_nxt;
    logic       w_valid_nxt;
    logic [3:0] w_event;
    logic [3:0] w_acc_mask;
    logic [3:0] w_pending_nxt;
    logic       w_accept;
    logic [1:0] w_start;

    // First set bit of p, searching upward from start with wrap-around.
    function automatic logic [1:0] f_encode(input logic [3:0] p, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        f_encode = 2'b00;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && p[idx]) begin
                f_encode = idx;
                found    = 1'b1;
            end
        end
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [1:0] r_last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 2'b11;
        end else if (w_accept && !i_clr) begin
            r_last_grant <= r_code;
        end
    end

    assign w_start = r_last_grant + 2'b01;
`else
    assign w_start = 2'b00;
`endif

    assign w_event    = (EDGE_MODE != 0) ? (i_req & ~r_req_d) : i_req;
    assign w_accept   = r_valid && i_ready;
    assign w_acc_mask = w_accept ? (4'b0001 << r_code) : 4'b0000;

    // A fresh event on a bit being accepted keeps it pending, so it is not lost.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr) begin
            w_pending_nxt = 4'b0000;
        end else begin
            w_pending_nxt = w_event | (r_pending & ~w_acc_mask);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        if (i_clr) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending != 4'b0000) begin
                        w_state_nxt = S_PRESENT;
                        w_code_nxt  = f_encode(r_pending, w_start);
                        w_valid_nxt = 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (w_accept) begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req_d    <= 4'b0000;
            r_pending  <= 4'b0000;
            r_code     <= 2'b00;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_d   <= i_req;
            r_pending <= w_pending_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            if (i_clr) begin
                r_overflow <= 1'b0;
            end else if ((w_event & r_pending & ~w_acc_mask) != 4'b0000) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_code     = r_code;
    assign o_valid    = r_valid;
    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_req_encoder_4to2.sv
// ============================================================================
// Module   : tb_req_encoder_4to2
// Directed scenarios plus randomized traffic against a cycle-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_req_encoder_4to2;

    localparam int EDGE_MODE = 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_req;
    logic       i_clr;
    logic       i_ready;
    logic [1:0] o_code;
    logic       o_valid;
    logic [3:0] o_pending;
    logic       o_overflow;

    int n_total = 0;
    int n_pass  = 0;

    logic [3:0] m_pend, m_reqd;
    logic       m_valid, m_ovf;
    logic [1:0] m_code, m_last;

    req_encoder_4to2 #(.EDGE_MODE(EDGE_MODE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_clr      (i_clr),
        .i_ready    (i_ready),
        .o_code     (o_code),
        .o_valid    (o_valid),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_pend  = 4'b0000;
        m_reqd  = 4'b0000;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_code  = 2'b00;
        m_last  = 2'b11;
    endtask

    function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] last);
        int base;
        int idx;
        base = 0;
`ifdef ROUND_ROBIN_EN
        base = (int'(last) + 1) % 4;
`endif
        pick = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            idx = (base + k) % 4;
            if (p[idx]) pick = 2'(idx);
        end
    endfunction

    task automatic model_edge(input logic [3:0] req, input logic clr, input logic rdy);
        logic [3:0] np;
        logic       acc;
        logic       ev;
        logic       hit;
        acc = m_valid && rdy;
        np  = m_pend;
        if (clr) begin
            np      = 4'b0000;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ev  = (EDGE_MODE != 0) ? (req[i] && !m_reqd[i]) : req[i];
                hit = acc && (int'(m_code) == i);
                if (ev) begin
                    if (m_pend[i] && !hit) m_ovf = 1'b1;
                    np[i] = 1'b1;
                end else if (hit) begin
                    np[i] = 1'b0;
                end
            end
            if (acc) begin
                m_valid = 1'b0;
                m_last  = m_code;
            end else if (!m_valid && m_pend != 4'b0000) begin
                m_valid = 1'b1;
                m_code  = pick(m_pend, m_last);
            end
        end
        m_pend = np;
        m_reqd = req;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(i_req, i_clr, i_ready);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 4'b1111; i_clr = 1'b0; i_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({o_valid, o_code, o_pending, o_overflow} !== 8'b0_00_0000_0)
            $display("FAIL reset_state: got v=%b c=%b p=%b o=%b, expected all zero", o_valid, o_code, o_pending, o_overflow);
        else n_pass++;
        rst_n = 1'b1;
        cyc();
        n_total++;
        if (o_pending !== 4'b1111) $display("FAIL reset_capture: got pending=%b, expected 1111", o_pending);
        else n_pass++;
        i_req = 4'b0000; i_clr = 1'b1;
        cyc();
        i_clr = 1'b0;
        n_total++;
        if ({o_valid, o_pending} !== 5'b0_0000) $display("FAIL reset_flush: got v=%b p=%b, expected v=0 p=0000", o_valid, o_pending);
        else n_pass++;
    endtask

    task automatic test_single_grant();
        i_ready = 1'b1; i_req = 4'b0100;
        cyc();
        n_total++;
        if ({o_valid, o_pending} !== 5'b0_0100) $display("FAIL single_pending: got v=%b p=%b, expected v=0 p=0100", o_valid, o_pending);
        else n_pass++;
        i_req = 4'b0000;
        cyc();
        n_total++;
        if ({o_valid, o_code} !== 3'b1_10) $display("FAIL single_present: got v=%b c=%b, expected v=1 c=10", o_valid, o_code);
        else n_pass++;
        cyc();
        n_total++;
        if ({o_valid, o_pending} !== 5'b0_0000) $display("FAIL single_accept: got v=%b p=%b, expected v=0 p=0000", o_valid, o_pending);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [1:0] exp_first, exp_second;
        exp_first  = pick(4'b1010, m_last);
        exp_second = (exp_first == 2'b01) ? 2'b11 : 2'b01;
`ifndef ROUND_ROBIN_EN
        exp_first  = 2'b01;
        exp_second = 2'b11;
`endif
        i_ready = 1'b1; i_req = 4'b1010;
        cyc();
        i_req = 4'b0000;
        cyc();
        n_total++;
        if ({o_valid, o_code} !== {1'b1, exp_first}) $display("FAIL prio_first: got v=%b c=%b, expected v=1 c=%b", o_valid, o_code, exp_first);
        else n_pass++;
        cyc();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL prio_bubble: got v=%b, expected v=0", o_valid);
        else n_pass++;
        cyc();
        n_total++;
        if ({o_valid, o_code} !== {1'b1, exp_second}) $display("FAIL prio_second: got v=%b c=%b, expected v=1 c=%b", o_valid, o_code, exp_second);
        else n_pass++;
        cyc();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0; i_req = 4'b0001;
        cyc();
        i_req = 4'b0000;
        cyc();
        for (int n = 0; n < 5; n++) begin
            i_req = (n == 1) ? 4'b0100 : 4'b0000;
            cyc();
            n_total++;
            if ({o_valid, o_code} !== 3'b1_00) $display("FAIL bp_hold%0d: got v=%b c=%b, expected v=1 c=00", n, o_valid, o_code);
            else n_pass++;
        end
        i_ready = 1'b1; i_req = 4'b0000;
        cyc();
        n_total++;
        if ({o_valid, o_pending} !== 5'b0_0100) $display("FAIL bp_accept: got v=%b p=%b, expected v=0 p=0100", o_valid, o_pending);
        else n_pass++;
        cyc();
        n_total++;
        if ({o_valid, o_code} !== 3'b1_10) $display("FAIL bp_next: got v=%b c=%b, expected v=1 c=10", o_valid, o_code);
        else n_pass++;
        cyc();
        i_ready = 1'b0;
    endtask

    task automatic test_overflow_clr();
        i_ready = 1'b0; i_req = 4'b0100;
        cyc();
        i_req = 4'b0000;
        cyc();
        i_req = 4'b0100;
        cyc();
        n_total++;
        if (o_overflow !== 1'b1) $display("FAIL ovf_set: got ovf=%b, expected 1", o_overflow);
        else n_pass++;
        i_req = 4'b0000;
        cyc();
        cyc();
        n_total++;
        if ({o_overflow, o_valid} !== 2'b11) $display("FAIL ovf_sticky: got ovf=%b v=%b, expected ovf=1 v=1", o_overflow, o_valid);
        else n_pass++;
        i_clr = 1'b1;
        cyc();
        i_clr = 1'b0;
        n_total++;
        if ({o_valid, o_pending, o_overflow} !== 6'b0_0000_0) $display("FAIL ovf_clr: got v=%b p=%b ovf=%b, expected 0 0000 0", o_valid, o_pending, o_overflow);
        else n_pass++;
    endtask

    task automatic test_collision();
        i_ready = 1'b0; i_req = 4'b0010;
        cyc();
        i_req = 4'b0000;
        cyc();
        n_total++;
        if ({o_valid, o_code} !== 3'b1_01) $display("FAIL coll_present: got v=%b c=%b, expected v=1 c=01", o_valid, o_code);
        else n_pass++;
        i_ready = 1'b1; i_req = 4'b0010;
        cyc();
        n_total++;
        if ({o_valid, o_pending, o_overflow} !== 6'b0_0010_0) $display("FAIL coll_keep: got v=%b p=%b ovf=%b, expected 0 0010 0", o_valid, o_pending, o_overflow);
        else n_pass++;
        i_req = 4'b0000;
        cyc();
        n_total++;
        if ({o_valid, o_code} !== 3'b1_01) $display("FAIL coll_repeat: got v=%b c=%b, expected v=1 c=01", o_valid, o_code);
        else n_pass++;
        cyc();
        i_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0; i_req = 4'b0001;
        cyc();
        i_req = 4'b0000;
        cyc();
        n_total++;
        if (o_valid !== 1'b1) $display("FAIL arst_pre: got v=%b, expected 1", o_valid);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_valid, o_pending} !== 5'b0_0000) $display("FAIL arst_drop: got v=%b p=%b, expected v=0 p=0000", o_valid, o_pending);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            i_req   = 4'($urandom & $urandom);
            i_ready = ($urandom_range(0, 2) != 0);
            i_clr   = ($urandom_range(0, 39) == 0);
            cyc();
            n_total++;
            if ({o_valid, o_code, o_pending, o_overflow} !== {m_valid, m_code, m_pend, m_ovf})
                $display("FAIL rand%0d: got v=%b c=%b p=%b o=%b, expected v=%b c=%b p=%b o=%b",
                         n, o_valid, o_code, o_pending, o_overflow, m_valid, m_code, m_pend, m_ovf);
            else n_pass++;
        end
        i_req = 4'b0000; i_clr = 1'b0; i_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_priority();
        test_backpressure();
        test_overflow_clr();
        test_collision();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
